// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential multiplier controller and its datapath top.
package seq_mult_pkg;

  localparam int unsigned DEFAULT_MAX_ITER = 3;
  localparam int unsigned DEFAULT_CNT_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    DONE,
    ERR
  } mult_state_t;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic clear;
    logic dec_b;
    logic load_f;
    logic busy;
    logic done;
    logic err;
  } ctrl_out_t;

  // Moore output decode; applied to the next state so outputs can be registered.
  function automatic ctrl_out_t decode_state(input mult_state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      LOAD: begin
        o.load_a = 1'b1;
        o.load_b = 1'b1;
        o.clear  = 1'b1;
        o.busy   = 1'b1;
      end
      TEST: o.busy = 1'b1;
      ADD: begin
        o.dec_b  = 1'b1;
        o.load_f = 1'b1;
        o.busy   = 1'b1;
      end
      DONE: begin
        o.done = 1'b1;
        o.busy = 1'b1;
      end
      ERR: begin
        o.err  = 1'b1;
        o.busy = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier controller: clearable, saturating at MAX_ITER.
module iter_counter
  import seq_mult_pkg::*;
#(
  parameter int unsigned MAX_ITER = DEFAULT_MAX_ITER,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max = (cnt_q == CNT_W'(MAX_ITER));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the sequential multiplier: load, repeated add/decrement until B is zero,
// with a bounded iteration count that flags a datapath which never reaches zero.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned MAX_ITER = DEFAULT_MAX_ITER,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic zero,
  output logic loadA,
  output logic loadB,
  output logic clear,
  output logic decB,
  output logic loadF,
  output logic busy,
  output logic done,
  output logic err
);

  mult_state_t state_q;
  mult_state_t state_d;
  ctrl_out_t   out_q;
  ctrl_out_t   out_d;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        at_max;

  iter_counter #(
    .MAX_ITER(MAX_ITER),
    .CNT_W   (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .at_max(at_max)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = LOAD;
        LOAD: begin
          state_d = TEST;
          cnt_clr = 1'b1;
        end
        TEST: begin
          if (zero) begin
            state_d = DONE;
          end else if (at_max) begin
            state_d = ERR;
          end else begin
            state_d = ADD;
          end
        end
        ADD: begin
          state_d = TEST;
          cnt_inc = 1'b1;
        end
        DONE:    state_d = IDLE;
        ERR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Decoding the next state keeps outputs registered yet aligned with the state they belong to.
    out_d = decode_state(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign loadA = out_q.load_a;
  assign loadB = out_q.load_b;
  assign clear = out_q.clear;
  assign decB  = out_q.dec_b;
  assign loadF = out_q.load_f;
  assign busy  = out_q.busy;
  assign done  = out_q.done;
  assign err   = out_q.err;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: a behavioural A/B/F datapath closes the loop and
// expected outcomes (kind, cycle, product) are queued by the driver and popped by the monitor.
module tb_seq_mult_ctrl;
  import seq_mult_pkg::*;

  localparam int unsigned MAX_ITER = 3;
  localparam int unsigned CNT_W    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic zero;
  logic loadA, loadB, clear, decB, loadF, busy, done, err;

  seq_mult_ctrl #(
    .MAX_ITER(MAX_ITER),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .zero (zero),
    .loadA(loadA),
    .loadB(loadB),
    .clear(clear),
    .decB (decB),
    .loadF(loadF),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural datapath: A/B operand registers, product accumulator F.
  int   a_op = 0;
  int   b_op = 0;
  bit   stuck = 1'b0;
  int   a_reg = 0;
  int   b_reg = 0;
  int   f_reg = 0;
  logic noise = 1'b0;

  always @(posedge clk) begin
    if (loadA) a_reg <= a_op;
    if (loadB) b_reg <= b_op;
    else if (decB) b_reg <= b_reg - 1;
    if (clear) f_reg <= 0;
    else if (loadF) f_reg <= f_reg + a_reg;
  end

  always @(negedge clk) noise <= 1'($urandom_range(0, 1));

  // The comparator is only meaningful while testing; elsewhere it carries noise the DUT must ignore.
  assign zero = (busy && !loadA && !decB && !done && !err) ? (!stuck && b_reg == 0) : noise;

  typedef struct {
    int kind;       // 0 done, 1 err, 2 aborted
    int load_cyc;
    int end_cyc;
    int product;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (loadA || loadB || clear) begin
        chk("load_strobes", int'({loadA, loadB, clear, decB, loadF}), 5'b11100);
        if (q.size() == 0) chk("load_expected", 0, 1);
        else chk("load_cycle", cyc, q[0].load_cyc);
      end
      if (decB || loadF) chk("add_strobes", int'({decB, loadF, loadB, clear}), 4'b1100);
      if (done || err) begin
        if (q.size() == 0) begin
          chk("unexpected_end", int'({done, err}), 0);
        end else begin
          mon_e = q.pop_front();
          chk("end_kind", err ? 1 : 0, mon_e.kind);
          chk("end_flags", int'({done, err, busy}), (mon_e.kind == 1) ? 3'b011 : 3'b101);
          chk("end_cycle", cyc, mon_e.end_cyc);
          chk("product", f_reg, mon_e.product);
        end
      end
    end
  end

  // Issues one transaction at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run(input int a, input int n, input bit stk, input bit do_abort,
                     input bit poke, input bit idle_abort);
    exp_t e;
    bit   seen;
    a_op  = a;
    b_op  = n;
    stuck = stk;
    e.kind     = do_abort ? 2 : (stk ? 1 : 0);
    e.load_cyc = cyc + 1;
    e.end_cyc  = stk ? cyc + 3 + 2 * int'(MAX_ITER) : cyc + 3 + 2 * n;
    e.product  = a * (stk ? int'(MAX_ITER) : n);
    q.push_back(e);
    start = 1'b1;
    abort = idle_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (do_abort && loadF) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        seen  = 1'b1;
        chk("abort_idle", busy, 0);
        e = q.pop_front();
      end else if (done || err) begin
        @(negedge clk);
        seen = 1'b1;
      end else begin
        start = poke && (i == 1);
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (!seen) begin
      chk("txn_timeout", 0, 1);
      q.delete();
    end else begin
      chk("idle_after", int'({busy, loadA, decB, done, err}), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   a, n, g;
    bit   stk, ab, pk;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({loadA, loadB, clear, decB, loadF, busy, done, err}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idle_busy", busy, 0);

    run(5, 2, 1'b0, 1'b0, 1'b0, 1'b0);  // B=2
    repeat (2) @(negedge clk);
    run(7, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // B=0
    run(9, 1, 1'b1, 1'b0, 1'b0, 1'b0);  // zero stuck low -> err
    run(6, 2, 1'b0, 1'b1, 1'b0, 1'b0);  // abort in first ADD
    run(4, 3, 1'b0, 1'b0, 1'b0, 1'b0);  // completes normally after abort
    run(2, 3, 1'b0, 1'b0, 1'b1, 1'b0);  // start poked while busy
    run(3, 1, 1'b0, 1'b0, 1'b0, 1'b1);  // start+abort together in IDLE
    run(11, 3, 1'b0, 1'b0, 1'b0, 1'b0); // back-to-back
    run(13, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      a   = int'($urandom_range(1, 15));
      n   = int'($urandom_range(0, MAX_ITER));
      stk = ($urandom_range(0, 4) == 0);
      pk  = ($urandom_range(0, 2) == 0);
      ab  = ($urandom_range(0, 5) == 0) && (stk || n > 0);
      g   = int'($urandom_range(0, 2));
      repeat (g) @(negedge clk);
      run(a, n, stk, ab, pk, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of an ADD cycle.
    a_op  = 3;
    b_op  = 1;
    stuck = 1'b1;
    e.kind     = 1;
    e.load_cyc = cyc + 1;
    e.end_cyc  = cyc + 3 + 2 * int'(MAX_ITER);
    e.product  = 9;
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !loadF; i++) @(negedge clk);
    chk("reset_reached_add", loadF, 1);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", int'({loadA, loadB, clear, decB, loadF, busy, done, err}), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_busy", busy, 0);
    run(8, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Control FSM for the 2-bit shift-free sequential multiplier datapath (operand registers A/B, product accumulator F, zero comparator on B). It accepts a one-cycle `start` request, sequences load, repeated-add and decrement steps until the datapath reports the B register is zero, then raises `done`. A bounded iteration counter flags a datapath that never reaches zero. It is the only block that drives the datapath control strobes.

## Interface
- `MAX_ITER`, default 3: maximum ADD steps before declaring error; must be ≥1; equals max value of a 2-bit B operand.
- `CNT_W`, default 2: width of iteration counter; must satisfy 2^CNT_W > MAX_ITER-… i.e. holds 0..MAX_ITER.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `abort`  in  1  synchronous abort; forces IDLE next edge from any non-IDLE state.
- `zero`  in  1  datapath comparator: B register equals 0.
- `loadA`  out  1  load A operand register.
- `loadB`  out  1  load B operand register.
- `clear`  out  1  clear product accumulator.
- `decB`  out  1  decrement B register.
- `loadF`  out  1  accumulate A into product.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse: iteration limit hit without `zero`.

## Operation
- States: IDLE, LOAD, TEST, ADD, DONE, ERR. All outputs Moore-decoded from state; no combinational path input→output.
- IDLE: all strobes 0. `start`=1 → LOAD. `start` outside IDLE ignored (no queuing).
- LOAD: `loadA`=`loadB`=`clear`=1 for exactly one cycle; iteration counter cleared → TEST.
- TEST: all strobes 0 (lets `zero` settle on loaded B). `zero`=1 → DONE; else if count==MAX_ITER → ERR; else → ADD.
- ADD: `decB`=`loadF`=1 for exactly one cycle; counter += 1 → TEST.
- DONE: `done`=1 one cycle → IDLE. ERR: `err`=1 one cycle → IDLE.
- `abort`=1 in any non-IDLE state: next state IDLE, counter cleared, no `done`/`err`; abort has priority over all other transitions. `abort` in IDLE has no effect; `start`+`abort` same cycle in IDLE → LOAD (abort ignored in IDLE).
- Counter saturates at MAX_ITER; never wraps.
- Strobes mutually exclusive by phase: never `loadB` with `decB`, never `clear` with `loadF`.

## Timing
- Reset (`rst_n`=0, async): state IDLE, counter 0, all outputs 0 immediately; release is synchronous-safe (first transition on first edge after deassert). Reset mid-operation discards the operation.
- `start` high at edge k → LOAD in cycle k+1, first TEST k+2.
- Operand B=n (n≤MAX_ITER, datapath decrements to zero after n ADDs): `done` high in cycle k+3+2n; `busy` high cycles k+1 … k+3+2n inclusive; next `start` accepted at edge k+4+2n.
- Non-reaching datapath: `err` high in cycle k+3+2·MAX_ITER.
- `zero` sampled only in TEST; value in other states ignored.

## Structure
- Package `seq_mult_pkg`: state enum typedef `mult_state_t` (IDLE, LOAD, TEST, ADD, DONE, ERR), default `MAX_ITER`/`CNT_W` constants, shared with datapath top.
- One sub-module: `iter_counter` (clear, increment, saturate at MAX_ITER, `at_max` flag).
- Top-level FSM: one sequential state register with async reset, one combinational next-state/output block.

## Test plan
- Reset: hold `rst_n`=0 mid-ADD → all outputs 0 same cycle; after release state IDLE, `busy`=0.
- B=2 (`zero` driven low until after 2nd ADD): `start` at edge 0 → `loadA/loadB/clear` cycle 1, `decB/loadF` cycles 3 and 5, `done` cycle 7, exactly 2 `loadF` pulses.
- B=0 (`zero`=1 after LOAD): `done` cycle 3, zero `decB`/`loadF` pulses.
- `zero` stuck 0, MAX_ITER=3: three ADD pulses, `err` cycle 9, no `done`, back to IDLE cycle 10.
- `abort` asserted in first ADD cycle → IDLE next edge, no `done`/`err`; new `start` then completes normally.
- `start` pulsed while busy → ignored; exactly one `done` per accepted start; back-to-back start at edge after `done` accepted.
